// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared constants, state encoding and cache-target codes for
//               the serial program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

  // Default frame geometry and inter-frame idle time
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_FRAME_W = DEF_ADDR_W + DEF_DATA_W;
  localparam int DEF_GAP_CYC = 2;

  // Loader state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_TAIL  = 3'd2,
    ST_GAP   = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  // Frame target select: which chip select carries the frame
  localparam logic TGT_ICACHE = 1'b0;
  localparam logic TGT_DCACHE = 1'b1;

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_loader_piso_shifter.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_piso_shifter
// Description : Parallel-load, LSB-first serializer with a bit counter and a
//               flag marking the last bit of the word.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_piso_shifter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  output logic         bit_o,
  output logic         last_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  sreg_q;
  logic [CW-1:0] cnt_q;

  // Load the word, then move one bit toward the LSB per shift step
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
      cnt_q  <= '0;
    end else if (shift_i) begin
      sreg_q <= {1'b0, sreg_q[W-1:1]};
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign bit_o  = sreg_q[0];
  assign last_o = (cnt_q == CW'(W - 1));

endmodule : prog_loader_piso_shifter
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Host-side master for the processor serial load port. Takes
//               address/data frames over valid/ready, serializes them onto
//               csi/csd/mosi and gates execution through en_proc.
//               Optional macro PROG_LOADER_AUTORUN_EN: a frame flagged last
//               starts execution automatically after its gap.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frm_valid_in,
  output logic              frm_ready_out,
  input  logic [ADDR_W-1:0] frm_addr_in,
  input  logic [DATA_W-1:0] frm_data_in,
  input  logic              frm_tgt_in,
  input  logic              frm_last_in,
  input  logic              run_in,
  output logic              csi_out,
  output logic              csd_out,
  output logic              mosi_out,
  output logic              en_proc_out,
  output logic              busy_out,
  output logic [4:0]        frames_sent_out
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          tgt_q, tgt_d;
  logic          csi_q, csi_d, csd_q, csd_d, mosi_q, mosi_d;
  logic          en_q, en_d, busy_q, busy_d;
  logic [4:0]    frames_q, frames_d;
  logic          w_accept, w_bit, w_last, w_shift;

`ifdef PROG_LOADER_AUTORUN_EN
  logic          last_q, last_d;
  logic          run_prev_q;
`else
  logic          w_unused_last;
  assign w_unused_last = frm_last_in;
`endif

  assign frm_ready_out = (state_q == ST_IDLE) & ~rst;
  assign w_accept      = frm_valid_in & frm_ready_out;
  assign w_shift       = (state_q == ST_SHIFT);

  prog_loader_piso_shifter #(.W(FRAME_W)) u_piso (
    .clk    (clk),
    .rst    (rst),
    .load_i (w_accept),
    .data_i ({frm_data_in, frm_addr_in}),
    .shift_i(w_shift),
    .bit_o  (w_bit),
    .last_o (w_last)
  );

  // Next state plus next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    tgt_d    = tgt_q;
    frames_d = frames_q;
`ifdef PROG_LOADER_AUTORUN_EN
    last_d   = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          tgt_d   = frm_tgt_in;
          state_d = ST_SHIFT;
`ifdef PROG_LOADER_AUTORUN_EN
          last_d  = frm_last_in;
`endif
        end else if (run_in) begin
          state_d = ST_RUN;
        end
      end
      ST_SHIFT: if (w_last) state_d = ST_TAIL;
      ST_TAIL: begin
        state_d  = ST_GAP;
        gap_d    = '0;
        frames_d = (frames_q == 5'd31) ? frames_q : frames_q + 5'd1;
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
`ifdef PROG_LOADER_AUTORUN_EN
          state_d = last_q ? ST_RUN : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_RUN: begin
`ifdef PROG_LOADER_AUTORUN_EN
        // A pending frame or a falling run request ends execution
        if (frm_valid_in || (run_prev_q && !run_in)) state_d = ST_IDLE;
`else
        if (!run_in) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Selected chip select is low only while shifting; the frame bits lag
    // cs by one cycle, so mosi shows the shifter LSB of the previous cycle.
    csi_d  = ~((state_d == ST_SHIFT) && (tgt_d == TGT_ICACHE));
    csd_d  = ~((state_d == ST_SHIFT) && (tgt_d == TGT_DCACHE));
    mosi_d = (state_q == ST_SHIFT) ? w_bit : 1'b0;
    en_d   = (state_d == ST_RUN);
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      tgt_q    <= TGT_ICACHE;
      csi_q    <= 1'b1;
      csd_q    <= 1'b1;
      mosi_q   <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      tgt_q    <= tgt_d;
      csi_q    <= csi_d;
      csd_q    <= csd_d;
      mosi_q   <= mosi_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      frames_q <= frames_d;
    end
  end

`ifdef PROG_LOADER_AUTORUN_EN
  // Last-frame flag and run request history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b0;
      run_prev_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      run_prev_q <= run_in;
    end
  end
`endif

  assign csi_out         = csi_q;
  assign csd_out         = csd_q;
  assign mosi_out        = mosi_q;
  assign en_proc_out     = en_q;
  assign busy_out        = busy_q;
  assign frames_sent_out = frames_q;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Scoreboard bench for prog_loader. Accepted frames queue their
//               expected serial image; a monitor reassembles each cs-low
//               burst from mosi and compares it against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       frm_valid, frm_ready, frm_tgt, frm_last, run;
  logic [3:0] frm_addr;
  logic [7:0] frm_data;
  logic       csi, csd, mosi, en_proc, busy;
  logic [4:0] frames;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prog_loader dut (
    .clk            (clk),
    .rst            (rst),
    .frm_valid_in   (frm_valid),
    .frm_ready_out  (frm_ready),
    .frm_addr_in    (frm_addr),
    .frm_data_in    (frm_data),
    .frm_tgt_in     (frm_tgt),
    .frm_last_in    (frm_last),
    .run_in         (run),
    .csi_out        (csi),
    .csd_out        (csd),
    .mosi_out       (mosi),
    .en_proc_out    (en_proc),
    .busy_out       (busy),
    .frames_sent_out(frames)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: reassemble each frame from the cs-low burst plus the tail cycle
  initial begin
    logic        tgt;
    logic        abort;
    logic [11:0] got;
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && (csi === 1'b0 || csd === 1'b0)) begin
        abort = 1'b0;
        got   = '0;
        tgt   = (csd === 1'b0);
        check("cs_overlap", {31'd0, (csi === 1'b0 && csd === 1'b0)}, 32'd0);
        check("mosi_j0", {31'd0, mosi}, 32'd0);
        check("en_while_cs", {31'd0, en_proc}, 32'd0);
        for (int j = 1; j <= 12; j++) begin
          @(negedge clk);
          if (rst === 1'b1) begin
            abort = 1'b1;
            break;
          end
          if (j < 12) begin
            check("cs_hold", {30'd0, csi, csd}, tgt ? 32'd2 : 32'd1);
            check("en_while_cs", {31'd0, en_proc}, 32'd0);
          end else begin
            check("cs_tail", {30'd0, csi, csd}, 32'd3);
          end
          got[j-1] = mosi;
        end
        if (!abort) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_unexpected: got 0x%0h, expected no frame", {tgt, got});
          end else begin
            e = exp_q.pop_front();
            check("frame", {19'd0, tgt, got}, {19'd0, e});
          end
        end
      end
    end
  end

  // Wait (bounded) for ready at a falling edge; returns the cycle stamp
  task automatic wait_ready(output int c);
    c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frm_ready === 1'b1) begin
        c = cyc;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL ready_timeout: got no ready, expected ready within 100 cycles");
  endtask

  // Offer one frame; called just after a rising edge, returns just after the
  // accepting edge. The stamp is the cycle count when ready was seen.
  task automatic send(input logic [3:0] a, input logic [7:0] d, input logic t,
                      input logic l, input bit push, input bit keep, output int acc);
    int c;
    frm_addr  = a;
    frm_data  = d;
    frm_tgt   = t;
    frm_last  = l;
    frm_valid = 1'b1;
    wait_ready(c);
    acc = c;
    if (c < 0) begin
      frm_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back({t, d, a});
    @(posedge clk);
    #1;
    if (!keep) frm_valid = 1'b0;
  endtask

  initial begin
    int c0, c1;
    rst = 1'b1; frm_valid = 1'b0; frm_addr = '0; frm_data = '0;
    frm_tgt = 1'b0; frm_last = 1'b0; run = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, frm_ready}, 32'd0);
    check("rst_cs", {30'd0, csi, csd}, 32'd3);
    check("rst_mosi_en", {30'd0, mosi, en_proc}, 32'd0);
    check("rst_frames", {27'd0, frames}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, frm_ready}, 32'd1);
    check("busy_after_rst", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Basic icache frame: spacing, frame count
    send(4'h3, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, c0);
    @(negedge clk);
    check("ready_in_shift", {31'd0, frm_ready}, 32'd0);
    check("busy_in_shift", {31'd0, busy}, 32'd1);
    wait_ready(c1);
    check("spacing", c1 - c0, 32'd16);
    check("frames_1", {27'd0, frames}, 32'd1);
    @(posedge clk); #1;

    // Same frame to the data cache
    send(4'h3, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, c0);
    wait_ready(c1);
    check("frames_2", {27'd0, frames}, 32'd2);
    @(posedge clk); #1;

    // Back-to-back with valid held; inputs change during the first shift
    send(4'h5, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, c0);
    send(4'hA, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0, c1);
    check("b2b_spacing", c1 - c0, 32'd16);
    wait_ready(c1);
    check("frames_4", {27'd0, frames}, 32'd4);
    @(posedge clk); #1;

    // Reset during shift bit j=6 aborts the frame
    send(4'h7, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, c0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs", {30'd0, csi, csd}, 32'd3);
    check("abort_mosi", {31'd0, mosi}, 32'd0);
    check("abort_frames", {27'd0, frames}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", {31'd0, frm_ready}, 32'd1);
    @(posedge clk); #1;

    // Run request from IDLE
    run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("run_en", {31'd0, en_proc}, 32'd1);
    check("run_ready", {31'd0, frm_ready}, 32'd0);
`ifndef PROG_LOADER_AUTORUN_EN
    @(posedge clk); #1;
    frm_valid = 1'b1; frm_addr = 4'h1; frm_data = 8'h11;
    repeat (3) begin
      @(negedge clk);
      check("run_ignores_valid", {30'd0, frm_ready, en_proc}, 32'd1);
    end
    @(posedge clk); #1;
    frm_valid = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    run = 1'b0;
    @(negedge clk);
    check("run_drop_en_still", {31'd0, en_proc}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("run_drop_en", {31'd0, en_proc}, 32'd0);
    check("run_drop_ready", {31'd0, frm_ready}, 32'd1);
    @(posedge clk); #1;

    // 33 frames: counter saturates at 31
    for (int i = 0; i < 33; i++) begin
      send(i[3:0], 8'(i * 7 + 1), i[0], 1'b0, 1'b1, 1'b0, c0);
    end
    wait_ready(c1);
    check("frames_sat", {27'd0, frames}, 32'd31);
    @(posedge clk); #1;

`ifdef PROG_LOADER_AUTORUN_EN
    // Last frame starts execution without run_in; a new frame ends it
    send(4'h2, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, c0);
    repeat (15) @(negedge clk);
    check("auto_gap_en", {31'd0, en_proc}, 32'd0);
    @(negedge clk);
    check("auto_en", {31'd0, en_proc}, 32'd1);
    check("auto_ready", {31'd0, frm_ready}, 32'd0);
    @(posedge clk); #1;
    send(4'h4, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, c0);
    @(negedge clk);
    check("auto_exit_en", {31'd0, en_proc}, 32'd0);
    wait_ready(c1);
    @(posedge clk); #1;
`endif

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_prog_loader
`default_nettype wire
